// File: rtl/icache_ctrl_pkg.sv
// icache_ctrl shared definitions
// FSM states, default geometry, pc field positions
package icache_pkg;
  typedef enum logic [1:0] {
    IDLE,
    MISS,
    FILL
  } state_e;

  localparam int OFFSET_W_D = 4;
  localparam int TAG_W_D    = 4;
  localparam int OFF_LSB    = 2;

  function automatic int tag_lsb(input int off_w);
    return OFF_LSB + off_w;
  endfunction
endpackage

// File: rtl/icache_ctrl_if.sv
// icache_ctrl memory read bus
// req held until ack sampled high
interface icache_ctrl_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/icache_ctrl_sat_counter.sv
// saturating event counter
// holds at all-ones, never wraps
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q;

  // count up on inc until saturated
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt_q <= '0;
    else if (inc_i && cnt_q != '1)
      cnt_q <= cnt_q + 1'b1;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/icache_ctrl.sv
// icache_ctrl: direct-mapped icache miss handler
// hit served same cycle, miss refilled over mem bus
module icache_ctrl
  import icache_pkg::*;
#(
  parameter int OFFSET_W = OFFSET_W_D,
  parameter int TAG_W    = TAG_W_D,
  parameter int CNT_W    = 16
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic [31:0]         pc,
  input  logic                fetch_req,
  input  logic                flush,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic                stall,
  output logic [OFFSET_W-1:0] cache_offset,
  output logic [TAG_W-1:0]    cache_tag,
  output logic                cache_en,
  output logic                cache_we_n,
  output logic [31:0]         cache_wdata,
  input  logic                cache_match,
  input  logic [31:0]         cache_data,
  icache_ctrl_if.master       mem,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);
  localparam int TAG_LSB = tag_lsb(OFFSET_W);

  state_e      state_q;
  logic [31:0] miss_addr_q;
  logic [31:0] fill_data_q;
  logic        mem_req_q;
  logic        kill_q;
  logic        hit;
  logic        miss;

  // array access, delivery and stall per state
  always_comb begin
    hit          = 1'b0;
    miss         = 1'b0;
    instr        = '0;
    instr_valid  = 1'b0;
    stall        = 1'b0;
    cache_offset = miss_addr_q[OFF_LSB +: OFFSET_W];
    cache_tag    = miss_addr_q[TAG_LSB +: TAG_W];
    cache_en     = 1'b0;
    cache_we_n   = 1'b1;
    unique case (state_q)
      IDLE: begin
        cache_offset = pc[OFF_LSB +: OFFSET_W];
        cache_tag    = pc[TAG_LSB +: TAG_W];
        cache_en     = fetch_req;
        hit          = fetch_req & cache_match & ~flush;
        miss         = fetch_req & ~cache_match & ~flush;
        instr        = hit ? cache_data : '0;
        instr_valid  = hit;
        stall        = miss;
      end
      MISS: stall = 1'b1;
      FILL: begin
        cache_en    = 1'b1;
        cache_we_n  = 1'b0;
        instr       = fill_data_q;
        instr_valid = ~kill_q & ~flush;
      end
      default: ;
    endcase
  end

  // miss FSM: latch address, run handshake, one-cycle fill
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      fill_data_q <= '0;
      mem_req_q   <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (miss) begin
          miss_addr_q <= pc & 32'hFFFF_FFFC;
          mem_req_q   <= 1'b1;
          state_q     <= MISS;
        end
        MISS: begin
          if (flush)
            kill_q <= 1'b1;
          if (mem.mem_ack) begin
            fill_data_q <= mem.mem_rdata;
            mem_req_q   <= 1'b0;
            state_q     <= FILL;
          end
        end
        FILL: begin
          kill_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cache_wdata  = fill_data_q;
  assign mem.mem_req  = mem_req_q;
  assign mem.mem_addr = miss_addr_q;

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (CLK),
    .rst_n (RSTn),
    .inc_i (hit),
    .cnt_o (hit_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (CLK),
    .rst_n (RSTn),
    .inc_i (miss),
    .cnt_o (miss_cnt)
  );
endmodule

// File: tb/tb_icache_ctrl.sv
// tb_icache_ctrl: scoreboard bench for icache_ctrl
// transaction-level cache model vs two DUTs (16b and 2b counters)
module tb_icache_ctrl;
  logic        CLK = 1'b0;
  logic        RSTn;
  logic [31:0] pc;
  logic        fetch_req, flush;
  logic [31:0] instr, instr2;
  logic        instr_valid, instr_valid2;
  logic        stall, stall2;
  logic [3:0]  cache_offset, cache_offset2;
  logic [3:0]  cache_tag, cache_tag2;
  logic        cache_en, cache_en2;
  logic        cache_we_n, cache_we_n2;
  logic [31:0] cache_wdata, cache_wdata2;
  logic        cache_match, cache_match2;
  logic [31:0] cache_data, cache_data2;
  logic [15:0] hit_cnt, miss_cnt;
  logic [1:0]  hit_cnt2, miss_cnt2;

  icache_ctrl_if mif();
  icache_ctrl_if mif2();
  assign mif2.mem_ack   = mif.mem_ack;
  assign mif2.mem_rdata = mif.mem_rdata;

  always #5 CLK = ~CLK;

  icache_ctrl dut (
    .CLK(CLK), .RSTn(RSTn), .pc(pc), .fetch_req(fetch_req),
    .flush(flush), .instr(instr), .instr_valid(instr_valid),
    .stall(stall), .cache_offset(cache_offset),
    .cache_tag(cache_tag), .cache_en(cache_en),
    .cache_we_n(cache_we_n), .cache_wdata(cache_wdata),
    .cache_match(cache_match), .cache_data(cache_data),
    .mem(mif.master), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  icache_ctrl #(.CNT_W(2)) dut2 (
    .CLK(CLK), .RSTn(RSTn), .pc(pc), .fetch_req(fetch_req),
    .flush(flush), .instr(instr2), .instr_valid(instr_valid2),
    .stall(stall2), .cache_offset(cache_offset2),
    .cache_tag(cache_tag2), .cache_en(cache_en2),
    .cache_we_n(cache_we_n2), .cache_wdata(cache_wdata2),
    .cache_match(cache_match2), .cache_data(cache_data2),
    .mem(mif2.master), .hit_cnt(hit_cnt2), .miss_cnt(miss_cnt2)
  );

  // external cache arrays (environment, one per DUT)
  bit          env_v [2][16] = '{default: 1'b0};
  logic [3:0]  env_t [2][16];
  logic [31:0] env_d [2][16];
  assign cache_match  = env_v[0][cache_offset] && env_t[0][cache_offset] == cache_tag;
  assign cache_data   = env_d[0][cache_offset];
  assign cache_match2 = env_v[1][cache_offset2] && env_t[1][cache_offset2] == cache_tag2;
  assign cache_data2  = env_d[1][cache_offset2];

  always @(posedge CLK) begin
    if (cache_en && !cache_we_n) begin
      env_v[0][cache_offset] <= 1'b1;
      env_t[0][cache_offset] <= cache_tag;
      env_d[0][cache_offset] <= cache_wdata;
    end
    if (cache_en2 && !cache_we_n2) begin
      env_v[1][cache_offset2] <= 1'b1;
      env_t[1][cache_offset2] <= cache_tag2;
      env_d[1][cache_offset2] <= cache_wdata2;
    end
  end

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // reference model: what the cache should hold, indexed by pc fields
  bit          ref_v [16] = '{default: 1'b0};
  logic [3:0]  ref_t [16];
  logic [31:0] ref_d [16];
  logic [31:0] mem_m [logic [31:0]];

  typedef struct { int cyc; logic [31:0] d; } dexp_t;
  typedef struct { int cyc; logic [3:0] off; logic [3:0] tg; logic [31:0] d; } fexp_t;
  dexp_t dq[$];
  dexp_t dq2[$];
  fexp_t fq[$];
  dexp_t me;
  fexp_t mf;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;
  bit          exp_req, exp_stall;
  logic [31:0] exp_mem_addr;
  int          exp_hit, exp_miss;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic mem_read(input logic [31:0] a, output logic [31:0] d);
    if (!mem_m.exists(a)) mem_m[a] = $urandom;
    d = mem_m[a];
  endtask

  // monitor: pop expectations whenever the DUTs present output
  always @(negedge CLK) begin
    if (RSTn && mon_en) begin
      if (instr_valid) begin
        if (dq.size() == 0) chk("unexpected_instr_valid", 1, 0);
        else begin
          me = dq.pop_front();
          chk("deliver_cycle", cyc, me.cyc);
          chk("instr", instr, me.d);
        end
      end
      if (instr_valid2) begin
        if (dq2.size() == 0) chk("dut2_unexpected_valid", 1, 0);
        else begin
          me = dq2.pop_front();
          chk("dut2_instr", instr2, me.d);
        end
      end
      if (!cache_we_n) begin
        if (fq.size() == 0) chk("unexpected_fill", 1, 0);
        else begin
          mf = fq.pop_front();
          chk("fill_cycle", cyc, mf.cyc);
          chk("fill_en", cache_en, 1);
          chk("fill_off", cache_offset, mf.off);
          chk("fill_tag", cache_tag, mf.tg);
          chk("fill_wdata", cache_wdata, mf.d);
        end
      end
      chk("mem_req", mif.mem_req, exp_req);
      if (mif.mem_req) chk("mem_addr", mif.mem_addr, exp_mem_addr);
      if (mif2.mem_req) chk("dut2_mem_addr", mif2.mem_addr, exp_mem_addr);
      chk("stall", stall, exp_stall);
      chk("hit_cnt", hit_cnt, sat(exp_hit, 65535));
      chk("miss_cnt", miss_cnt, sat(exp_miss, 65535));
      chk("dut2_stall", stall2, exp_stall);
      chk("dut2_hit_cnt", hit_cnt2, sat(exp_hit, 3));
      chk("dut2_miss_cnt", miss_cnt2, sat(exp_miss, 3));
    end
  end

  task automatic tick();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      pc = $urandom;
      fetch_req = 1'b0;
      flush = 1'b0;
      exp_req = 1'b0;
      exp_stall = 1'b0;
      tick();
    end
  endtask

  task automatic flush_idle(input logic [31:0] a);
    pc = a;
    fetch_req = 1'b1;
    flush = 1'b1;
    exp_req = 1'b0;
    exp_stall = 1'b0;
    tick();
    flush = 1'b0;
    fetch_req = 1'b0;
  endtask

  // one fetch; kill_at = cycle after detect that flush is raised (<1: none)
  task automatic fetch(input logic [31:0] a, input int lat, input int kill_at);
    logic [3:0]  ix, tg;
    logic [31:0] d;
    int          t;
    ix = a[5:2];
    tg = a[9:6];
    pc = a;
    fetch_req = 1'b1;
    flush = 1'b0;
    mif.mem_ack = 1'b0;
    exp_req = 1'b0;
    t = cyc;
    if (ref_v[ix] && ref_t[ix] == tg) begin
      dq.push_back('{t, ref_d[ix]});
      dq2.push_back('{t, ref_d[ix]});
      exp_stall = 1'b0;
      tick();
      exp_hit++;
      fetch_req = 1'b0;
    end else begin
      mem_read(a & 32'hFFFF_FFFC, d);
      if (kill_at < 1) begin
        dq.push_back('{t + 2 + lat, d});
        dq2.push_back('{t + 2 + lat, d});
      end
      fq.push_back('{t + 2 + lat, ix, tg, d});
      exp_stall = 1'b1;
      tick();
      exp_miss++;
      exp_mem_addr = a & 32'hFFFF_FFFC;
      exp_req = 1'b1;
      for (int k = 1; k <= lat + 1; k++) begin
        pc = $urandom;
        fetch_req = 1'($urandom);
        flush = (k == kill_at);
        mif.mem_ack = (k == lat + 1);
        mif.mem_rdata = (k == lat + 1) ? d : $urandom;
        tick();
      end
      exp_req = 1'b0;
      exp_stall = 1'b0;
      pc = $urandom;
      fetch_req = 1'b0;
      flush = (kill_at == lat + 2);
      mif.mem_ack = 1'($urandom);
      mif.mem_rdata = $urandom;
      tick();
      flush = 1'b0;
      mif.mem_ack = 1'b0;
      ref_v[ix] = 1'b1;
      ref_t[ix] = tg;
      ref_d[ix] = d;
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  tg;
    int          r, lat, ka;
    RSTn = 1'b0;
    pc = '0;
    fetch_req = 1'b0;
    flush = 1'b0;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = '0;
    exp_req = 1'b0;
    exp_stall = 1'b0;
    exp_mem_addr = '0;
    exp_hit = 0;
    exp_miss = 0;
    mem_m[32'h40] = 32'hDEADBEEF;

    #12;
    chk("rst_instr", instr, 0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_stall", stall, 0);
    chk("rst_mem_req", mif.mem_req, 0);
    chk("rst_mem_addr", mif.mem_addr, 0);
    chk("rst_we_n", cache_we_n, 1);
    chk("rst_en", cache_en, 0);
    chk("rst_wdata", cache_wdata, 0);
    chk("rst_hit_cnt", hit_cnt, 0);
    chk("rst_miss_cnt", miss_cnt, 0);
    tick();
    RSTn = 1'b1;
    mon_en = 1'b1;
    idle(2);

    fetch(32'h40, 3, -1);
    fetch(32'h40, 0, -1);
    fetch(32'h80, 2, -1);
    fetch(32'h40, 1, -1);
    fetch(32'hC0, 0, -1);
    idle(1);
    fetch(32'h1C4, 4, 2);
    fetch(32'h1C4, 0, -1);
    flush_idle(32'h40);
    fetch(32'h104, 2, 4);
    repeat (5) fetch(32'h104, 0, -1);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
        | $urandom_range(0, 3);
      if (r < 7) begin
        lat = $urandom_range(0, 4);
        ka = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, lat + 2)) : -1;
        fetch(a, lat, ka);
      end else if (r < 8) flush_idle(a);
      else idle(1);
    end

    tg = ref_v[7] ? ref_t[7] + 4'd1 : 4'd3;
    a = {22'd0, tg, 4'h7, 2'b00};
    pc = a;
    fetch_req = 1'b1;
    flush = 1'b0;
    exp_stall = 1'b1;
    exp_req = 1'b0;
    tick();
    exp_miss++;
    exp_mem_addr = a;
    exp_req = 1'b1;
    fetch_req = 1'b0;
    pc = $urandom;
    tick();
    #1;
    RSTn = 1'b0;
    #1;
    chk("rstmid_mem_req", mif.mem_req, 0);
    chk("rstmid_stall", stall, 0);
    chk("rstmid_we_n", cache_we_n, 1);
    chk("rstmid_miss_cnt", miss_cnt, 0);
    exp_hit = 0;
    exp_miss = 0;
    exp_req = 1'b0;
    exp_stall = 1'b0;
    tick();
    RSTn = 1'b1;
    idle(1);
    fetch(a, 1, -1);
    fetch(a, 0, -1);
    idle(3);

    chk("pending_deliveries", dq.size(), 0);
    chk("dut2_pending_deliveries", dq2.size(), 0);
    chk("pending_fills", fq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
